// File: rtl/frame_capture_buffer_if.sv
// Frame capture buffer bus: capture control, sample input, reader port, status.
// master = client side (drives control/samples/reads), slave = buffer side.
interface frame_capture_buffer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_LENGTH  = 10,
  parameter int NUM_CHANNELS = 2
);
  localparam int CH_W =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                               start;
  logic                               abort;
  logic                               frame_done;
  logic                               in_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                               rd_en;
  logic [ADDR_LENGTH-1:0]             rd_addr;
  logic [CH_W-1:0]                    rd_channel;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_valid;
  logic                               frame_ready;
  logic                               busy;
  logic [ADDR_LENGTH:0]               wr_count;
  logic [15:0]                        overrun_count;

  modport master (
    output start, abort, frame_done,
    output in_valid, in_data,
    output rd_en, rd_addr, rd_channel,
    input  rd_data, rd_valid,
    input  frame_ready, busy,
    input  wr_count, overrun_count
  );

  modport slave (
    input  start, abort, frame_done,
    input  in_valid, in_data,
    input  rd_en, rd_addr, rd_channel,
    output rd_data, rd_valid,
    output frame_ready, busy,
    output wr_count, overrun_count
  );
endinterface

// File: rtl/frame_capture_buffer.sv
// Multi-channel frame capture memory: fills 2**ADDR_LENGTH slots, holds the
// frame until released, per-channel reads, saturating overrun count.
// Ports: clk, reset (async active-low), bus (frame_capture_buffer_if.slave).
// Option: FRAME_CAPTURE_OUTPUT_REG_EN adds a second read pipeline stage.
module frame_capture_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_LENGTH  = 10,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  frame_capture_buffer_if.slave  bus
);
  localparam int CH_W =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH  = 2 ** ADDR_LENGTH;
  localparam int WORD_W = NUM_CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_LENGTH:0] LAST =
    (ADDR_LENGTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_LENGTH:0] cnt_q, cnt_d;
  logic [15:0]          ovr_q, ovr_d;
  logic                 wr_en;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     rd_word;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    // Samples arriving while FULL are dropped and counted,
    // even on the cycle the frame is released or aborted.
    if (state_q == FULL && bus.in_valid && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = FILL;
            cnt_d   = '0;
            ovr_d   = '0;
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST)
              state_d = FULL;
          end
        end
        FULL: begin
          if (bus.frame_done) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[cnt_q[ADDR_LENGTH-1:0]] <= bus.in_data;
  end

  // Read-during-write sees the old word since the write lands at the edge.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    rd_mux  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (bus.rd_channel == CH_W'(c))
        rd_mux = rd_word[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.rd_en;
      if (bus.rd_en)
        s1_data <= rd_mux;
    end
  end

`ifdef FRAME_CAPTURE_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= s1_data;
    end
  end

  assign bus.rd_data  = s2_data;
  assign bus.rd_valid = s2_valid;
`else
  assign bus.rd_data  = s1_data;
  assign bus.rd_valid = s1_valid;
`endif

  assign bus.frame_ready   = (state_q == FULL);
  assign bus.busy          = (state_q == FILL);
  assign bus.wr_count      = cnt_q;
  assign bus.overrun_count = ovr_q;
endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed bench for frame_capture_buffer: fill, channel reads,
// overrun, abort, async reset, saturation, out-of-range channel.
module tb_frame_capture_buffer;
`ifdef FRAME_CAPTURE_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_capture_buffer_if #(
    .DATA_WIDTH(16), .ADDR_LENGTH(4), .NUM_CHANNELS(2)
  ) bus ();

  frame_capture_buffer #(
    .DATA_WIDTH(16), .ADDR_LENGTH(4), .NUM_CHANNELS(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  frame_capture_buffer_if #(
    .DATA_WIDTH(16), .ADDR_LENGTH(4), .NUM_CHANNELS(3)
  ) bus3 ();

  frame_capture_buffer #(
    .DATA_WIDTH(16), .ADDR_LENGTH(4), .NUM_CHANNELS(3)
  ) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  addr;
    logic        ch;
    logic [15:0] exp;
  } rvec_t;

  rvec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string nm,
                         input logic [3:0] a,
                         input logic ch,
                         input logic [15:0] exp);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    bus.rd_channel = ch;
    step();
    bus.rd_en = 1'b0;
    for (int k = 1; k < LAT; k++) step();
    chk({nm, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({nm, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    tbl[0] = '{4'd5,  1'b0, 16'h0005};
    tbl[1] = '{4'd5,  1'b1, 16'h0105};
    tbl[2] = '{4'd0,  1'b0, 16'h0000};
    tbl[3] = '{4'd0,  1'b1, 16'h0100};
    tbl[4] = '{4'd15, 1'b1, 16'h010F};
    tbl[5] = '{4'd10, 1'b0, 16'h000A};

    bus.start = 0; bus.abort = 0; bus.frame_done = 0;
    bus.in_valid = 0; bus.in_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.rd_channel = '0;
    bus3.start = 0; bus3.abort = 0; bus3.frame_done = 0;
    bus3.in_valid = 0; bus3.in_data = '0;
    bus3.rd_en = 0; bus3.rd_addr = '0; bus3.rd_channel = '0;

    step(); step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.frame_ready), 0);
    chk("rst_wrcnt", 32'(bus.wr_count), 0);
    chk("rst_ovr", 32'(bus.overrun_count), 0);
    chk("rst_rdvalid", 32'(bus.rd_valid), 0);
    chk("rst_rddata", 32'(bus.rd_data), 0);
    reset = 1'b1;
    step();

    bus.start = 1; step(); bus.start = 0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_wrcnt", 32'(bus.wr_count), 0);

    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1;
      bus.in_data = {16'h0100 + 16'(i), 16'(i)};
      step();
      chk("fill_wrcnt", 32'(bus.wr_count), 32'(i + 1));
      chk("fill_ready", 32'(bus.frame_ready), (i == 15) ? 1 : 0);
      chk("fill_busy", 32'(bus.busy), (i == 15) ? 0 : 1);
    end
    bus.in_valid = 0;

    for (int i = 0; i < 6 + LAT - 1; i++) begin
      if (i < 6) begin
        bus.rd_en = 1;
        bus.rd_addr = tbl[i].addr;
        bus.rd_channel = tbl[i].ch;
      end else begin
        bus.rd_en = 0;
      end
      step();
      if (i - (LAT - 1) >= 0) begin
        chk("tbl_valid", 32'(bus.rd_valid), 1);
        chk("tbl_data", 32'(bus.rd_data),
            32'(tbl[i - (LAT - 1)].exp));
      end
    end
    bus.rd_en = 0;
    step();
    chk("tbl_valid_drop", 32'(bus.rd_valid), 0);
    chk("rd_hold", 32'(bus.rd_data), 32'h000A);

    bus.rd_en = 1; bus.rd_addr = 4'd5; bus.rd_channel = 1'b1;
    step();
    bus.rd_en = 0;
    chk("lat_c1_valid", 32'(bus.rd_valid), (LAT == 1) ? 1 : 0);
    step();
    chk("lat_c2_valid", 32'(bus.rd_valid), (LAT == 2) ? 1 : 0);
    chk("lat_data", 32'(bus.rd_data), 32'h0105);
    step(); step();

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_data = 32'hDEADBEEF;
      step();
    end
    chk("ovr5", 32'(bus.overrun_count), 5);
    chk("ovr5_ready", 32'(bus.frame_ready), 1);
    bus.frame_done = 1;
    step();
    bus.frame_done = 0; bus.in_valid = 0;
    chk("ovr6", 32'(bus.overrun_count), 6);
    chk("rel_busy", 32'(bus.busy), 1);
    chk("rel_ready", 32'(bus.frame_ready), 0);
    chk("rel_wrcnt", 32'(bus.wr_count), 0);
    do_read("slot0_ch0", 4'd0, 1'b0, 16'h0000);
    do_read("slot0_ch1", 4'd0, 1'b1, 16'h0100);

    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1; bus.in_data = 32'hAAAA5555;
      step();
    end
    bus.in_valid = 0;
    chk("pre_abort_wrcnt", 32'(bus.wr_count), 7);
    bus.abort = 1; step(); bus.abort = 0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_wrcnt", 32'(bus.wr_count), 0);
    chk("abort_ovr_kept", 32'(bus.overrun_count), 6);
    bus.start = 1; step(); bus.start = 0;
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_wrcnt", 32'(bus.wr_count), 0);
    chk("restart_ovr", 32'(bus.overrun_count), 0);
    chk("restart_ready", 32'(bus.frame_ready), 0);

    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = 32'h12345678;
      step();
    end
    bus.in_valid = 0;
    chk("pre_rst_wrcnt", 32'(bus.wr_count), 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_wrcnt", 32'(bus.wr_count), 0);
    chk("arst_rddata", 32'(bus.rd_data), 0);
    chk("arst_ready", 32'(bus.frame_ready), 0);
    step();
    reset = 1'b1;
    step();
    bus.start = 1; step(); bus.start = 0;
    chk("post_rst_busy", 32'(bus.busy), 1);
    chk("post_rst_wrcnt", 32'(bus.wr_count), 0);

    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1; bus.in_data = 32'(i);
      step();
    end
    chk("sat_ready", 32'(bus.frame_ready), 1);
    for (int i = 0; i < 65540; i++) step();
    bus.in_valid = 0;
    chk("sat_ovr", 32'(bus.overrun_count), 32'hFFFF);
    chk("sat_hold_ready", 32'(bus.frame_ready), 1);

    bus3.start = 1; step(); bus3.start = 0;
    bus3.in_valid = 1;
    bus3.in_data = {16'h3333, 16'h2222, 16'h1111};
    step();
    bus3.in_valid = 0;
    bus3.rd_en = 1; bus3.rd_addr = 4'd0; bus3.rd_channel = 2'd2;
    step();
    bus3.rd_channel = 2'd3;
    if (LAT == 2) step();
    chk("nc3_ch2", 32'(bus3.rd_data), 32'h3333);
    step();
    bus3.rd_en = 0;
    if (LAT == 2) step();
    chk("nc3_ch3", 32'(bus3.rd_data), 32'h0000);
    chk("nc3_valid", 32'(bus3.rd_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
